uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
- UART transmitter: the counterpart to the UART receive path. Serialises one parallel data word per frame onto a single line.
- Frame format: start bit (0), DATA_WIDTH data bits LSB-first, optional parity bit, one stop bit (1).
- Advances exactly one bit per CLK cycle; CLK is the TX baud-rate clock from the system clock divider.
- Sits between the async FIFO read side (or register-file/ALU result path) and the TX pin.

Parameters:
- DATA_WIDTH, 8, width of P_DATA and number of data bits per frame (legal range 5..9).

Ports:
- CLK, input, 1, TX baud clock; all state updates on the rising edge.
- RST, input, 1, asynchronous, active-low reset.
- P_DATA, input, DATA_WIDTH, parallel word to transmit.
- Data_Valid, input, 1, request to send P_DATA.
- PAR_EN, input, 1, 1 = parity bit inserted.
- PAR_TYP, input, 1, 0 = even parity, 1 = odd parity.
- TX_OUT, output, 1, serial line (idle high).
- Busy, output, 1, high while a frame is on the line.

Behaviour:
- Reset: TX_OUT=1, Busy=0, state=IDLE, bit counter=0, data/parity-config registers cleared. Asserting RST mid-frame aborts the frame immediately; line returns high, with no partial completion.
- Outputs are registered and glitch-free; no combinational path from inputs to TX_OUT or Busy.
- Acceptance: when state=IDLE and Data_Valid=1 at edge k:
  - latch P_DATA, PAR_EN and PAR_TYP;
  - after edge k: state=START, TX_OUT=0, Busy=1.
- Data_Valid is ignored while Busy=1. Input changes mid-frame do not affect the frame in flight.
- States:
  - IDLE: TX_OUT=1, Busy=0.
  - START: one cycle, TX_OUT=0.
  - DATA: DATA_WIDTH cycles, TX_OUT=data[i] with i=0..DATA_WIDTH-1. Counter wraps to 0 on the last bit.
  - PARITY: one cycle, only if latched PAR_EN=1.
  - STOP: one cycle, TX_OUT=1, Busy=1.
  - STOP always goes to IDLE, where Busy falls.
- Transitions:
  - IDLE->START on accept.
  - START->DATA.
  - DATA->PARITY when counter=DATA_WIDTH-1 and PAR_EN=1; DATA->STOP when counter=DATA_WIDTH-1 and PAR_EN=0.
  - PARITY->STOP.
  - STOP->IDLE.
- Parity: even = XOR-reduce of latched data; odd = inverted XOR-reduce. Computed from latched data only.
- Frame length with Busy=1: 2+DATA_WIDTH(+1 if parity) cycles, i.e. 11 for 8 data bits with parity, 10 without.
- Minimum inter-frame gap is one IDLE cycle. A Data_Valid held high continuously starts a new frame on the edge after Busy falls.
- Illegal state encoding recovers to IDLE with TX_OUT=1.

Decomposition:
- Shared package uart_pkg:
  - state encoding constants IDLE, START, DATA, PARITY, STOP (3-bit);
  - parity type constants PAR_EVEN=0, PAR_ODD=1.
- One natural sub-module: uart_tx_parity. Combinational parity from latched data plus PAR_TYP, instantiated once.
- FSM, bit counter and output mux stay in uart_tx_frame.

Test Plan:
- 0xA5, PAR_EN=1, PAR_TYP=0, single Data_Valid pulse -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,0(parity),1(stop). Busy high for exactly 11 cycles, then TX_OUT=1 and Busy=0.
- 0xA5, PAR_EN=1, PAR_TYP=1 -> parity bit=1. Same frame as above otherwise.
- 0x3C, PAR_EN=0 -> 0,0,0,1,1,1,1,0,0,1. Busy high 10 cycles, no parity cycle.
- Data_Valid held high with P_DATA changing to 0xFF mid-frame -> first frame carries original data unchanged. Exactly one IDLE cycle (TX_OUT=1, Busy=0) follows, then the second frame carries 0xFF.
- RST pulsed low during data bit 4 of 0x00 frame -> TX_OUT=1 and Busy=0 asynchronously. After release, a new Data_Valid produces a complete correct frame.
- PAR_EN toggled from 1 to 0 mid-frame -> parity bit still sent, because config is latched at acceptance.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding and
// parity-type codes used by the frame serialiser and its parity helper.
package uart_pkg;

  // FSM state encoding (3-bit, legacy-compatible constants)
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  // Parity type as seen on PAR_TYP
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_parity.sv
// Combinational parity generator for the UART transmitter. Works only on
// the word latched at frame acceptance, so the parity bit cannot change
// while a frame is on the line.
module uart_tx_parity
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);

  // Even parity is the XOR-reduce; odd parity is its inverse.
  always_comb begin
    par_bit = (par_typ == PAR_ODD) ? ~(^data) : (^data);
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: serialises one DATA_WIDTH-bit word per frame as
// start(0), data LSB-first, optional parity, stop(1). One bit per CLK,
// where CLK is the TX baud clock. TX_OUT and Busy come straight from flops.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  logic [2:0]            state, state_nxt;
  logic [CNT_W-1:0]      bit_cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0] data_reg;
  logic                  par_en_reg, par_typ_reg;
  logic                  tx_nxt, busy_nxt;
  logic                  load;
  logic                  par_bit;

  uart_tx_parity #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .data    (data_reg),
    .par_typ (par_typ_reg),
    .par_bit (par_bit)
  );

  // Next-state, next-counter and next line value; outputs are then
  // registered so the pin sees the value of the state being entered.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned -- otherwise synthesis infers a latch.
    state_nxt = state;
    cnt_nxt   = bit_cnt;
    tx_nxt    = 1'b1;
    busy_nxt  = 1'b1;
    load      = 1'b0;
    case (state)
      IDLE: begin
        busy_nxt = 1'b0;
        if (Data_Valid) begin
          load      = 1'b1;
          state_nxt = START;
          tx_nxt    = 1'b0;
          busy_nxt  = 1'b1;
        end
      end
      START: begin
        state_nxt = DATA;
        cnt_nxt   = '0;
        tx_nxt    = data_reg[0];
      end
      DATA: begin
        if (bit_cnt == LAST_BIT) begin
          cnt_nxt = '0;
          if (par_en_reg) begin
            state_nxt = PARITY;
            tx_nxt    = par_bit;
          end else begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end
        end else begin
          cnt_nxt = bit_cnt + CNT_W'(1);
          tx_nxt  = data_reg[cnt_nxt];
        end
      end
      PARITY: begin
        state_nxt = STOP;
        tx_nxt    = 1'b1;
      end
      STOP: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
      default: begin
        // Unused encodings fall back to an idle, high line.
        state_nxt = IDLE;
        cnt_nxt   = '0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State, counter, outputs and the per-frame latched word/configuration.
  always_ff @(posedge CLK or negedge RST) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!RST) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      data_reg    <= '0;
      par_en_reg  <= 1'b0;
      par_typ_reg <= 1'b0;
      TX_OUT      <= 1'b1;
      Busy        <= 1'b0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= cnt_nxt;
      TX_OUT  <= tx_nxt;
      Busy    <= busy_nxt;
      if (load) begin
        data_reg    <= P_DATA;
        par_en_reg  <= PAR_EN;
        par_typ_reg <= PAR_TYP;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: hand-written frame bit sequences are
// compared cycle by cycle, sampling on the falling edge of CLK.
module tb_uart_tx_frame;

  logic       CLK;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       TX_OUT;
  logic       Busy;

  int checks   = 0;
  int failures = 0;

  uart_tx_frame #(
    .DATA_WIDTH(8)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Check n line bits (exp[n-1] is the first bit on the line) with Busy
  // high throughout, then the idle cycle after. Called at the falling edge
  // just after the accepting rising edge.
  // mode 0: drop Data_Valid after acceptance
  // mode 1: keep Data_Valid high, change P_DATA to 0xFF mid-frame
  // mode 2: drop Data_Valid, flip PAR_EN to 0 and PAR_TYP to 1 mid-frame
  task automatic check_frame(input string tag, input logic [15:0] exp, input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_tx%0d", tag, i), {31'd0, TX_OUT}, {31'd0, exp[n-1-i]});
      check($sformatf("%s_busy%0d", tag, i), {31'd0, Busy}, 32'd1);
      if (i == 0 && mode != 1) Data_Valid = 1'b0;
      if (i == 3 && mode == 1) P_DATA = 8'hFF;
      if (i == 3 && mode == 2) begin
        PAR_EN  = 1'b0;
        PAR_TYP = 1'b1;
      end
      @(negedge CLK);
    end
    check($sformatf("%s_idle_tx", tag), {31'd0, TX_OUT}, 32'd1);
    check($sformatf("%s_idle_busy", tag), {31'd0, Busy}, 32'd0);
  endtask

  task automatic request(input logic [7:0] d, input logic pen, input logic ptyp);
    P_DATA     = d;
    PAR_EN     = pen;
    PAR_TYP    = ptyp;
    Data_Valid = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST        = 1'b0;
    P_DATA     = 8'h00;
    Data_Valid = 1'b0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_tx", {31'd0, TX_OUT}, 32'd1);
    check("rst_busy", {31'd0, Busy}, 32'd0);
    RST = 1'b1;
    @(negedge CLK);
    check("idle_tx", {31'd0, TX_OUT}, 32'd1);
    check("idle_busy", {31'd0, Busy}, 32'd0);

    // 0xA5 even parity: 0,1,0,1,0,0,1,0,1,0,1
    request(8'hA5, 1'b1, 1'b0);
    check_frame("a5_even", 16'b0_10100101_0_1, 11, 0);
    @(negedge CLK);

    // 0xA5 odd parity: parity bit 1
    request(8'hA5, 1'b1, 1'b1);
    check_frame("a5_odd", 16'b0_10100101_1_1, 11, 0);
    @(negedge CLK);

    // 0x3C no parity: 0,0,0,1,1,1,1,0,0,1
    request(8'h3C, 1'b0, 1'b0);
    check_frame("3c_nopar", 16'b0_00111100_1, 10, 0);
    @(negedge CLK);

    // Data_Valid held: 0x81 even (parity 0), one idle cycle, then 0xFF even (parity 0)
    request(8'h81, 1'b1, 1'b0);
    check_frame("held_81", 16'b0_10000001_0_1, 11, 1);
    @(negedge CLK);
    check_frame("held_ff", 16'b0_11111111_0_1, 11, 0);
    @(negedge CLK);

    // Config latched: 0x01 even parity (1) still sent after PAR_EN drops
    request(8'h01, 1'b1, 1'b0);
    check_frame("latched_cfg", 16'b0_10000000_1_1, 11, 2);
    @(negedge CLK);

    // Reset during data bit 4 of a 0x00 frame
    request(8'h00, 1'b0, 1'b0);
    Data_Valid = 1'b0;
    repeat (5) @(negedge CLK);
    check("pre_rst_tx", {31'd0, TX_OUT}, 32'd0);
    check("pre_rst_busy", {31'd0, Busy}, 32'd1);
    RST = 1'b0;
    #1;
    check("async_rst_tx", {31'd0, TX_OUT}, 32'd1);
    check("async_rst_busy", {31'd0, Busy}, 32'd0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("post_rst_tx", {31'd0, TX_OUT}, 32'd1);
    check("post_rst_busy", {31'd0, Busy}, 32'd0);

    // Full frame after reset: 0x3C odd parity (four ones -> parity 1)
    request(8'h3C, 1'b1, 1'b1);
    check_frame("after_rst", 16'b0_00111100_1_1, 11, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
